// File: rtl/delay_chain_pkg.sv
// Shared types and helpers for the programmable delay line.
//   dc_state_e : controller state (FILL while the line refills, RUN when valid)
//   len_ok     : range check for a requested delay (1..max_len)
//   ptr_sub    : modular pointer subtraction, no power-of-2 assumption
package delay_chain_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dc_state_e;

  // Requested delay is legal when 1 <= len <= max_len.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

  // (ptr - off) mod max_len; callers guarantee ptr < max_len and off < max_len.
  function automatic int unsigned ptr_sub(input int unsigned ptr,
                                          input int unsigned off,
                                          input int unsigned max_len);
    return (ptr >= off) ? (ptr - off) : (ptr + max_len - off);
  endfunction

endpackage

// File: rtl/delay_chain_ctrl_ram.sv
// Simple dual-port RAM: synchronous write, combinational read, no reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module dc_sdp_ram #(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port, sees the old contents during a write cycle
  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_chain_ctrl.sv
// Runtime-programmable memory-based delay line with fill tracking.
// A circular buffer is written every enabled cycle; the read address trails the
// write pointer by (len-1). After a delay change the line refills and dout_vld
// stays low until every sample in the window belongs to the new delay.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the line by one sample
//   din        : sample input
//   cfg_len    : requested delay (1..MAX_LEN)
//   cfg_load   : strobe applying cfg_len
//   cfg_err    : one-cycle pulse for an out-of-range cfg_len
//   cfg_busy   : high while refilling
//   dout       : delayed sample, zero while dout_vld is low
//   dout_vld   : dout is a genuine sample delayed by exactly len
module delay_chain_ctrl
  import delay_chain_pkg::*;
#(
  parameter  int unsigned DW      = 8,
  parameter  int unsigned MAX_LEN = 16,
  parameter  int unsigned DEF_LEN = 5,
  localparam int unsigned AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [AW:0]   cfg_len,
  input  logic          cfg_load,
  output logic          cfg_err,
  output logic          cfg_busy,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int unsigned LW = AW + 1;

  dc_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0] ram_rdata, rd_data, dout_d;
  logic          vld_d, err_d, busy_d, load_ok;

  // Read trails the write pointer by len-1 entries, modulo MAX_LEN
  assign rd_addr = AW'(ptr_sub(32'(wr_ptr_q), 32'(len_q) - 32'd1, MAX_LEN));
  // len==1 degenerates to a plain register: bypass the RAM
  assign rd_data = (len_q == LW'(1)) ? din : ram_rdata;
  assign cnt_inc = cnt_q + LW'(1);

  dc_sdp_ram #(
    .DW    (DW),
    .DEPTH (MAX_LEN)
  ) u_ram (
    .clk   (clk),
    .we    (en),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    dout_d   = dout;
    vld_d    = dout_vld;
    err_d    = 1'b0;
    load_ok  = cfg_load && len_ok(32'(cfg_len), MAX_LEN);

    if (cfg_load && !load_ok) err_d = 1'b1;

    if (en) wr_ptr_d = (wr_ptr_q == AW'(MAX_LEN - 1)) ? '0 : wr_ptr_q + AW'(1);

    if (load_ok) begin
      // New delay: discard the window and start counting afresh
      len_d   = cfg_len;
      state_d = FILL;
      cnt_d   = '0;
      dout_d  = '0;
      vld_d   = 1'b0;
      if (en) begin
        cnt_d = LW'(1);
        if (cfg_len == LW'(1)) begin
          state_d = RUN;
          vld_d   = 1'b1;
          dout_d  = din;
        end
      end
    end else if (en) begin
      unique case (state_q)
        FILL: begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = RUN;
            vld_d   = 1'b1;
            dout_d  = rd_data;
          end else begin
            dout_d  = '0;
          end
        end
        RUN: begin
          vld_d  = 1'b1;
          dout_d = rd_data;
        end
        default: state_d = FILL;
      endcase
    end

    busy_d = (state_d == FILL);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= LW'(DEF_LEN);
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      cfg_err  <= 1'b0;
      cfg_busy <= 1'b1;
    end else begin
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      dout     <= dout_d;
      dout_vld <= vld_d;
      cfg_err  <= err_d;
      cfg_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Scoreboard bench for delay_chain_ctrl: the driver computes the expected
// outputs for every clocked step and queues them; the monitor pops and compares
// just after each checked rising edge.
module tb_delay_chain_ctrl;

  localparam int unsigned DW      = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned AW      = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, cfg_load, cfg_err, cfg_busy, dout_vld;
  logic [DW-1:0] din, dout;
  logic [AW:0]   cfg_len;
  logic          chk_req;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] dout;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t exp_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  // Bench model of the delay law
  int            mlen, fill, sn;
  logic [DW-1:0] hist [0:1023];
  logic          cur_vld;
  logic [DW-1:0] cur_dout;

  always #5 clk = ~clk;

  delay_chain_ctrl #(
    .DW      (DW),
    .MAX_LEN (MAX_LEN),
    .DEF_LEN (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .cfg_len  (cfg_len),
    .cfg_load (cfg_load),
    .cfg_err  (cfg_err),
    .cfg_busy (cfg_busy),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clocked step: drive inputs, advance the model, queue the expectation
  task automatic step(input logic e, input logic l, input int cl);
    logic ok;
    exp_t x;
    @(negedge clk);
    ok       = l && (cl >= 1) && (cl <= int'(MAX_LEN));
    chk_req  = 1'b1;
    en       = e;
    cfg_load = l;
    cfg_len  = (AW+1)'(cl);
    din      = e ? DW'(sn + 1) : 8'hEE;
    if (ok) begin
      mlen     = cl;
      fill     = 0;
      cur_vld  = 1'b0;
      cur_dout = '0;
    end
    if (e) begin
      sn++;
      hist[sn] = din;
      if (fill < mlen) fill++;
      cur_vld  = (fill >= mlen);
      cur_dout = cur_vld ? hist[sn - mlen + 1] : '0;
    end
    x.vld  = cur_vld;
    x.dout = cur_dout;
    x.busy = !cur_vld;
    x.err  = l && !ok;
    exp_q.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  task automatic model_reset();
    mlen     = 5;
    fill     = 0;
    cur_vld  = 1'b0;
    cur_dout = '0;
  endtask

  // Monitor: compare after every checked edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (rst_n && chk_req) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("dout_vld", int'(dout_vld), int'(x.vld));
          chk("dout",     int'(dout),     int'(x.dout));
          chk("cfg_busy", int'(cfg_busy), int'(x.busy));
          chk("cfg_err",  int'(cfg_err),  int'(x.err));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    chk_req  = 1'b0;
    en       = 1'b0;
    cfg_load = 1'b0;
    cfg_len  = '0;
    din      = '0;
    sn       = 0;
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_dout",     int'(dout),     0);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 1);
    chk("rst_cfg_err",  int'(cfg_err),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default delay of 5, valid from the 5th enabled edge
    run(20);

    // Disabled cycles hold everything
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    run(19);

    // Shorten to 3 on sample 40: 40 reappears on the 3rd enabled edge
    step(1'b1, 1'b1, 3);
    run(5);

    // len=1 then len=16 across several pointer wraps
    step(1'b1, 1'b1, 1);
    run(6);
    step(1'b1, 1'b1, 16);
    run(39);

    // Rejected loads: stream continues, single-cycle error pulses
    step(1'b1, 1'b1, 0);
    run(3);
    step(1'b1, 1'b1, 17);
    run(3);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    run(2);

    // Accepted load without en clears outputs on that edge
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 0);
    run(4);

    // Asynchronous reset mid-run
    @(negedge clk);
    chk_req  = 1'b0;
    en       = 1'b0;
    cfg_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",     int'(dout),     0);
    chk("arst_dout_vld", int'(dout_vld), 0);
    chk("arst_cfg_busy", int'(cfg_busy), 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(10);

    step(1'b0, 1'b0, 0);
    @(negedge clk);
    chk_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
